// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Moore control FSM for a multi-cycle MIPS datapath with a shared
// instruction/data memory port. It decodes opcode (instruction[31:26] from
// the instruction register) and drives every datapath select/enable each
// cycle. Memory accesses wait on mem_ready. Illegal opcodes and memory
// accesses that exceed MEM_TIMEOUT wait cycles park the FSM in HALT with an
// error code.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   opcode        instruction[31:26] from the instruction register
//   mem_ready     memory access completes this cycle
//   mem_read      memory read request
//   mem_write     memory write request
//   i_or_d        memory address select (0 = PC, 1 = ALU out)
//   ir_write      load the instruction register
//   pc_write      unconditional PC update
//   pc_write_cond PC update when ALU zero (beq)
//   pc_source     0 = ALU result, 1 = branch target, 2 = jump target
//   alu_src_a     0 = PC, 1 = read_data_1
//   alu_src_b     0 = rd2, 1 = 4, 2 = sext imm, 3 = sext imm << 2
//   alu_op        0 = add, 1 = sub, 2 = funct field
//   reg_dst       write register select (0 = ins[20:16], 1 = ins[15:11])
//   reg_write     register file write enable
//   mem_to_reg    write data select (0 = ALU out, 1 = memory data)
//   halted        FSM is in HALT
//   err_code      0 = none, 1 = illegal opcode, 2 = memory timeout
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int STATE_W     = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [1:0] err_code
);

  typedef enum logic [STATE_W-1:0] {
    ST_RST    = STATE_W'(0),
    ST_FETCH  = STATE_W'(1),
    ST_DECODE = STATE_W'(2),
    ST_MEM_ADR= STATE_W'(3),
    ST_MEM_RD = STATE_W'(4),
    ST_MEM_WB = STATE_W'(5),
    ST_MEM_WR = STATE_W'(6),
    ST_EXEC_R = STATE_W'(7),
    ST_ALU_WB = STATE_W'(8),
    ST_EXEC_I = STATE_W'(9),
    ST_IMM_WB = STATE_W'(10),
    ST_BRANCH = STATE_W'(11),
    ST_JUMP   = STATE_W'(12),
    ST_HALT   = STATE_W'(13)
  } state_t;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_ADDI  = 6'b001000;

  localparam logic [1:0]  ERR_ILLEGAL = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd2;

  // Counter value in the wait cycle that would reach the limit.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] wait_cnt_r;
  logic [1:0]  err_code_r;
  logic [1:0]  err_next_s;
  logic        in_wait_s;
  logic        timeout_s;

  // The counter only runs while a memory access is stalled; it clears in
  // every other cycle, so it is always zero on entry to an access state.
  assign in_wait_s = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) ||
                     (state_r == ST_MEM_WR);
  assign timeout_s = in_wait_s && !mem_ready && (wait_cnt_r == WAIT_LAST);
  assign err_code  = err_code_r;

  // State, wait counter and sticky error code registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RST;
      wait_cnt_r <= 16'd0;
      err_code_r <= 2'd0;
    end else begin
      state_r    <= next_state_s;
      err_code_r <= err_next_s;
      if (in_wait_s && !mem_ready) begin
        wait_cnt_r <= wait_cnt_r + 16'd1;
      end else begin
        wait_cnt_r <= 16'd0;
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    next_state_s  = state_r;
    err_next_s    = err_code_r;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;
    case (state_r)
      ST_RST: begin
        next_state_s = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        // IR load and PC+4 commit only when the instruction word arrives.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          next_state_s = ST_DECODE;
        end else if (timeout_s) begin
          next_state_s = ST_HALT;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:      next_state_s = ST_EXEC_R;
          OP_LW, OP_SW:  next_state_s = ST_MEM_ADR;
          OP_BEQ:        next_state_s = ST_BRANCH;
          OP_J:          next_state_s = ST_JUMP;
          OP_ADDI:       next_state_s = ST_EXEC_I;
          default: begin
            next_state_s = ST_HALT;
            err_next_s   = ERR_ILLEGAL;
          end
        endcase
      end
      ST_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == OP_LW) begin
          next_state_s = ST_MEM_RD;
        end else if (opcode == OP_SW) begin
          next_state_s = ST_MEM_WR;
        end else begin
          // Opcode changed under us since DECODE: treat as illegal.
          next_state_s = ST_HALT;
          err_next_s   = ERR_ILLEGAL;
        end
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          next_state_s = ST_MEM_WB;
        end else if (timeout_s) begin
          next_state_s = ST_HALT;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          next_state_s = ST_MEM_RD;
        end
      end
      ST_MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          next_state_s = ST_FETCH;
        end else if (timeout_s) begin
          next_state_s = ST_HALT;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          next_state_s = ST_MEM_WR;
        end
      end
      ST_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'd2;
        next_state_s = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'd2;
        next_state_s = ST_IMM_WB;
      end
      ST_IMM_WB: begin
        reg_write    = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        next_state_s  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write     = 1'b1;
        pc_source    = 2'd2;
        next_state_s = ST_FETCH;
      end
      ST_HALT: begin
        halted       = 1'b1;
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mips_multicycle_control. Instructions are expanded
// into an expected per-cycle queue of {mem_ready to drive, opcode to drive,
// expected outputs} from the instruction-level cycle table, then replayed
// against the DUT. Opcode and mem_ready are randomised wherever the control
// must ignore them.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

  localparam int TO = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op, err_code;
  logic       alu_src_a, reg_dst, reg_write, mem_to_reg, halted;
  logic [18:0] obs;

  typedef struct packed {
    logic        rdy;
    logic [5:0]  op;
    logic [18:0] exp;
  } step_t;

  step_t      q[$];
  logic [1:0] exp_err;
  int         total;
  int         bad;

  mips_multicycle_control #(.STATE_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .halted(halted), .err_code(err_code)
  );

  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, reg_write,
                mem_to_reg, halted, err_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector in the same field order as obs.
  function automatic logic [18:0] v(input logic mr, mw, iod, irw, pcw, pcc,
                                    input logic [1:0] pcs, input logic asa,
                                    input logic [1:0] asb, aop,
                                    input logic rd, rw, m2r, h,
                                    input logic [1:0] ec);
    return {mr, mw, iod, irw, pcw, pcc, pcs, asa, asb, aop, rd, rw, m2r, h, ec};
  endfunction

  function automatic logic [18:0] v_fetch(input logic r);
    return v(1'b1,1'b0,1'b0,r,r,1'b0,2'd0,1'b0,2'd1,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_decode();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd3,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_memadr();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd2,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_memrd();
    return v(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_memwb();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b1,1'b1,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_memwr();
    return v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_execr();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd0,2'd2,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_aluwb();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,1'b1,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_execi();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd2,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_immwb();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b1,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_branch();
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b1,2'd0,2'd1,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_jump();
    return v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0);
  endfunction
  function automatic logic [18:0] v_halt(input logic [1:0] ec);
    return v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b1,ec);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction
  function automatic logic rrdy();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic [5:0] op, input logic [18:0] e);
    step_t s;
    s.rdy = rdy; s.op = op; s.exp = e;
    q.push_back(s);
  endtask

  // One memory access (0 fetch, 1 read, 2 write) with a number of wait cycles.
  task automatic push_access(input int kind, input int waits, output bit ok);
    logic [18:0] stall_v, done_v;
    stall_v = (kind == 0) ? v_fetch(1'b0) : (kind == 1) ? v_memrd() : v_memwr();
    done_v  = (kind == 0) ? v_fetch(1'b1) : (kind == 1) ? v_memrd() : v_memwr();
    for (int i = 0; i < waits && i < TO; i++) push(1'b0, rop(), stall_v);
    if (waits >= TO) begin
      exp_err = 2'd2;
      ok = 1'b0;
    end else begin
      push(1'b1, rop(), done_v);
      ok = 1'b1;
    end
  endtask

  task automatic model_instr(input logic [5:0] op, input int wf, input int wm,
                             output bit stopped);
    bit ok;
    stopped = 1'b0;
    push_access(0, wf, ok);
    if (!ok) begin
      stopped = 1'b1;
    end else begin
      push(rrdy(), op, v_decode());
      case (op)
        OP_R:    begin push(rrdy(), rop(), v_execr()); push(rrdy(), rop(), v_aluwb()); end
        OP_ADDI: begin push(rrdy(), rop(), v_execi()); push(rrdy(), rop(), v_immwb()); end
        OP_BEQ:  push(rrdy(), rop(), v_branch());
        OP_J:    push(rrdy(), rop(), v_jump());
        OP_LW: begin
          push(rrdy(), op, v_memadr());
          push_access(1, wm, ok);
          if (ok) push(rrdy(), rop(), v_memwb());
          else stopped = 1'b1;
        end
        OP_SW: begin
          push(rrdy(), op, v_memadr());
          push_access(2, wm, ok);
          if (!ok) stopped = 1'b1;
        end
        default: begin
          exp_err = 2'd1;
          stopped = 1'b1;
        end
      endcase
    end
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++) push(1'(i & 1), rop(), v_halt(exp_err));
  endtask

  // Replays the expected queue one clock per entry.
  task automatic run_queue(input string name);
    step_t s;
    int idx;
    idx = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      opcode = s.op;
      mem_ready = s.rdy;
      @(negedge clk);
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL %s step %0d: got %b want %b", name, idx, obs, s.exp);
      end
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 19'd0) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", obs, 19'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_err = 2'd0;
  endtask

  task automatic test_reset();
    bit st;
    reset = 1'b0; mem_ready = 1'b0; opcode = 6'd0; exp_err = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 19'd0) begin
      bad++;
      $display("FAIL reset_init: got %b want %b", obs, 19'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Bring an lw into MEM_RD and stall it there, then reset mid-access.
    push_access(0, 0, st);
    push(1'b0, OP_LW, v_decode());
    push(1'b0, OP_LW, v_memadr());
    push(1'b0, rop(), v_memrd());
    push(1'b0, rop(), v_memrd());
    run_queue("reset_pre");
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid_memrd: got %b want %b", obs, 19'd0);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== 19'd0) begin
      bad++;
      $display("FAIL reset_held: got %b want %b", obs, 19'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    total++;
    if (obs !== v_fetch(1'b0)) begin
      bad++;
      $display("FAIL reset_to_fetch: got %b want %b", obs, v_fetch(1'b0));
    end
  endtask

  task automatic test_rtype();
    bit st;
    model_instr(OP_R, 0, 0, st);
    push(1'b0, rop(), v_fetch(1'b0));   // cycle 5 is FETCH again
    push(1'b1, rop(), v_fetch(1'b1));
    push(1'b1, OP_ADDI, v_decode());
    push(rrdy(), rop(), v_execi());
    push(rrdy(), rop(), v_immwb());
    run_queue("rtype");
  endtask

  task automatic test_lw_waits();
    bit st;
    model_instr(OP_LW, 2, 2, st);
    model_instr(OP_SW, 1, 3, st);
    run_queue("lw_waits");
  endtask

  task automatic test_branch_jump();
    bit st;
    model_instr(OP_BEQ, 0, 0, st);
    model_instr(OP_J, 0, 0, st);
    model_instr(OP_J, 2, 0, st);
    run_queue("branch_jump");
  endtask

  task automatic test_illegal();
    bit st;
    model_instr(6'b111111, 0, 0, st);
    push_halt(50);
    run_queue("illegal");
    do_reset();
  endtask

  task automatic test_timeout();
    bit st;
    model_instr(OP_R, TO, 0, st);       // fetch timeout after TO wait cycles
    push_halt(5);
    run_queue("timeout_fetch");
    do_reset();
    model_instr(OP_ADDI, TO - 1, 0, st); // ready arrives in the limit cycle
    model_instr(OP_LW, 0, TO - 1, st);
    model_instr(OP_LW, 1, TO, st);       // read timeout
    push_halt(3);
    run_queue("timeout_rd");
    do_reset();
    model_instr(OP_SW, 0, TO, st);       // write timeout
    push_halt(3);
    run_queue("timeout_wr");
    do_reset();
  endtask

  task automatic test_random();
    bit st;
    logic [5:0] op;
    int wf, wm;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        6: op = OP_LW;
        7: op = OP_R;
        8: op = rop();
        default: op = OP_SW;
      endcase
      wf = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
      wm = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
      model_instr(op, wf, wm, st);
      if (st) begin
        push_halt(3);
        run_queue("random");
        do_reset();
      end else begin
        run_queue("random");
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_rtype();
    test_lw_waits();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
